pe_load_sequencer: RTL and testbench

//  Sequences one pe_top pass: config pulse, ce window, weight/feature streaming from the GLBs, completion wait, psum drain.

---
 rtl/pe_load_sequencer_pkg.sv | 21 ++
 rtl/pe_load_sequencer_if.sv | 62 ++++++
 rtl/pe_load_sequencer_glb_stream_rd.sv | 52 +++++
 rtl/pe_load_sequencer.sv | 155 +++++++++++++++
 tb/tb_pe_load_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_load_sequencer_pkg.sv
// Shared definitions for the pe_top load sequencer: default widths, CE window length
// and the 3-bit FSM state encoding.
package pe_load_sequencer_pkg;

  localparam int unsigned DefDataWidth  = 16;
  localparam int unsigned DefWAddrWidth = 7;
  localparam int unsigned DefFAddrWidth = 6;
  localparam int unsigned DefCeCycles   = 2;
  localparam int unsigned StateWidth    = 3;

  typedef enum logic [StateWidth-1:0] {
    StIdle    = 3'd0,
    StCfg     = 3'd1,
    StCe      = 3'd2,
    StLoad    = 3'd3,
    StDrain   = 3'd4,
    StWaitFin = 3'd5,
    StPsum    = 3'd6
  } seq_state_e;

endpackage

// File: rtl/pe_load_sequencer_if.sv
// Bundle of control, GLB read-port and pe_top bus signals around the load sequencer.
// master = sequencer side, slave = environment (GLBs, pe_top, controller).
interface pe_load_sequencer_if
  import pe_load_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DefDataWidth,
  parameter int unsigned W_ADDR_WIDTH = DefWAddrWidth,
  parameter int unsigned F_ADDR_WIDTH = DefFAddrWidth
) ();

  logic                    start;
  logic                    mode;
  logic [W_ADDR_WIDTH-1:0] w_base;
  logic [W_ADDR_WIDTH-1:0] w_len;
  logic [F_ADDR_WIDTH-1:0] f_base;
  logic [F_ADDR_WIDTH-1:0] f_len;

  logic                    weight_glb_rd_en;
  logic [W_ADDR_WIDTH-1:0] weight_glb_addr;
  logic [DATA_WIDTH-1:0]   weight_glb_rdata;
  logic                    feature_glb_rd_en;
  logic [F_ADDR_WIDTH-1:0] feature_glb_addr;
  logic [DATA_WIDTH-1:0]   feature_glb_rdata;

  logic                    pe_weight_load_ready;
  logic                    pe_ifmap_load_ready;
  logic                    mac_finish;
  logic                    clip_finish_flg;

  logic                    start_config;
  logic                    ce;
  logic                    start_weight_load;
  logic                    start_feature_load;
  logic [DATA_WIDTH-1:0]   bus_weight_in;
  logic                    bus_weight_valid;
  logic [DATA_WIDTH-1:0]   bus_feature_in;
  logic                    bus_feature_valid;
  logic                    psum_out_start;
  logic                    busy;
  logic                    done;

  modport master (
    input  start, mode, w_base, w_len, f_base, f_len,
    input  weight_glb_rdata, feature_glb_rdata,
    input  pe_weight_load_ready, pe_ifmap_load_ready, mac_finish, clip_finish_flg,
    output weight_glb_rd_en, weight_glb_addr, feature_glb_rd_en, feature_glb_addr,
    output start_config, ce, start_weight_load, start_feature_load,
    output bus_weight_in, bus_weight_valid, bus_feature_in, bus_feature_valid,
    output psum_out_start, busy, done
  );

  modport slave (
    output start, mode, w_base, w_len, f_base, f_len,
    output weight_glb_rdata, feature_glb_rdata,
    output pe_weight_load_ready, pe_ifmap_load_ready, mac_finish, clip_finish_flg,
    input  weight_glb_rd_en, weight_glb_addr, feature_glb_rd_en, feature_glb_addr,
    input  start_config, ce, start_weight_load, start_feature_load,
    input  bus_weight_in, bus_weight_valid, bus_feature_in, bus_feature_valid,
    input  psum_out_start, busy, done
  );

endinterface

// File: rtl/pe_load_sequencer_glb_stream_rd.sv
// One GLB read stream: latches base/len, issues reads while ready, delays rd_en into a
// bus valid that lines up with the GLB's one-cycle read data.
module pe_load_sequencer_glb_stream_rd #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  active,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  done
);

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  valid_q;

  // A zero-length stream is complete as soon as it is latched.
  assign done  = (cnt_q == len_q);
  assign rd_en = active && !done && ready;
  assign addr  = base_q + cnt_q;
  assign data  = rdata;
  assign valid = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (clear) begin
        base_q <= base;
        len_q  <= len;
        cnt_q  <= '0;
      end else if (rd_en) begin
        cnt_q <= cnt_q + ADDR_WIDTH'(1);
      end
      valid_q <= rd_en;
    end
  end

endmodule

// File: rtl/pe_load_sequencer.sv
// Sequences one pe_top pass: config pulse, CE window, concurrent weight/feature GLB
// streaming, completion wait and psum drain request.
module pe_load_sequencer
  import pe_load_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DefDataWidth,
  parameter int unsigned W_ADDR_WIDTH = DefWAddrWidth,
  parameter int unsigned F_ADDR_WIDTH = DefFAddrWidth,
  parameter int unsigned CE_CYCLES    = DefCeCycles
) (
  input logic                 clk,
  input logic                 rst,
  pe_load_sequencer_if.master bus
);

  localparam int unsigned CeCntW = (CE_CYCLES > 1) ? $clog2(CE_CYCLES) : 1;
  localparam logic [CeCntW-1:0] CeLast = CeCntW'(CE_CYCLES - 1);

  seq_state_e        state_q;
  logic              mode_q;
  logic [CeCntW-1:0] ce_cnt_q;
  logic              start_config_q;
  logic              ce_q;
  logic              load_pulse_q;
  logic              psum_q;
  logic              done_q;

  logic                    latch;
  logic                    stream_active;
  logic                    fin_flag;
  logic                    w_done;
  logic                    f_done;
  logic                    w_rd_en;
  logic [W_ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic                    w_valid;
  logic                    f_rd_en;
  logic [F_ADDR_WIDTH-1:0] f_addr;
  logic [DATA_WIDTH-1:0]   f_data;
  logic                    f_valid;

  assign latch         = (state_q == StIdle) && bus.start;
  // The LOAD entry cycle only carries the load-start pulses; reads begin after it.
  assign stream_active = (state_q == StLoad) && !load_pulse_q;
  assign fin_flag      = mode_q ? bus.clip_finish_flg : bus.mac_finish;

  pe_load_sequencer_glb_stream_rd #(
    .ADDR_WIDTH (W_ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_weight_stream (
    .clk    (clk),
    .rst    (rst),
    .clear  (latch),
    .active (stream_active),
    .base   (bus.w_base),
    .len    (bus.w_len),
    .ready  (bus.pe_weight_load_ready),
    .rdata  (bus.weight_glb_rdata),
    .rd_en  (w_rd_en),
    .addr   (w_addr),
    .data   (w_data),
    .valid  (w_valid),
    .done   (w_done)
  );

  pe_load_sequencer_glb_stream_rd #(
    .ADDR_WIDTH (F_ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_feature_stream (
    .clk    (clk),
    .rst    (rst),
    .clear  (latch),
    .active (stream_active),
    .base   (bus.f_base),
    .len    (bus.f_len),
    .ready  (bus.pe_ifmap_load_ready),
    .rdata  (bus.feature_glb_rdata),
    .rd_en  (f_rd_en),
    .addr   (f_addr),
    .data   (f_data),
    .valid  (f_valid),
    .done   (f_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      mode_q         <= 1'b0;
      ce_cnt_q       <= '0;
      start_config_q <= 1'b0;
      ce_q           <= 1'b0;
      load_pulse_q   <= 1'b0;
      psum_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      start_config_q <= 1'b0;
      load_pulse_q   <= 1'b0;
      psum_q         <= 1'b0;
      done_q         <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            mode_q         <= bus.mode;
            start_config_q <= 1'b1;
            state_q        <= StCfg;
          end
        end
        StCfg: begin
          ce_q     <= 1'b1;
          ce_cnt_q <= '0;
          state_q  <= StCe;
        end
        StCe: begin
          if (ce_cnt_q == CeLast) begin
            ce_q         <= 1'b0;
            load_pulse_q <= 1'b1;
            state_q      <= StLoad;
          end else begin
            ce_cnt_q <= ce_cnt_q + CeCntW'(1);
          end
        end
        StLoad: begin
          if (w_done && f_done) state_q <= StDrain;
        end
        StDrain: state_q <= StWaitFin;
        StWaitFin: begin
          if (fin_flag) begin
            psum_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StPsum;
          end
        end
        StPsum:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.weight_glb_rd_en   = w_rd_en;
  assign bus.weight_glb_addr    = w_addr;
  assign bus.feature_glb_rd_en  = f_rd_en;
  assign bus.feature_glb_addr   = f_addr;
  assign bus.bus_weight_in      = w_data;
  assign bus.bus_weight_valid   = w_valid;
  assign bus.bus_feature_in     = f_data;
  assign bus.bus_feature_valid  = f_valid;
  assign bus.start_config       = start_config_q;
  assign bus.ce                 = ce_q;
  assign bus.start_weight_load  = load_pulse_q;
  assign bus.start_feature_load = load_pulse_q;
  assign bus.psum_out_start     = psum_q;
  assign bus.done               = done_q;
  assign bus.busy               = (state_q != StIdle);

endmodule

// File: tb/tb_pe_load_sequencer.sv
// Self-checking bench for pe_load_sequencer: GLB memory models, per-cycle stream model
// and pass-level timing expectations derived from the sequencing rules.
module tb_pe_load_sequencer;
  import pe_load_sequencer_pkg::*;

  localparam int CeCycles = int'(DefCeCycles);

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] wmem [128];
  logic [15:0] fmem [64];

  pe_load_sequencer_if bus ();

  pe_load_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // GLB models: registered read, data valid one cycle after rd_en.
  always @(posedge clk) begin
    if (bus.weight_glb_rd_en === 1'b1) bus.weight_glb_rdata <= wmem[bus.weight_glb_addr];
    if (bus.feature_glb_rd_en === 1'b1) bus.feature_glb_rdata <= fmem[bus.feature_glb_addr];
  end

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < 128; i++) wmem[i] = rnd ? 16'($urandom) : 16'(i + 1);
    for (int i = 0; i < 64; i++) fmem[i] = rnd ? 16'($urandom) : 16'(i + 1);
  endtask

  function automatic logic pick_ready(input int pat, input int k);
    case (pat)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      default: return (k < 0) || (k % 3 == 0);
    endcase
  endfunction

  task automatic check_quiet(input string tag);
    logic [15:0] got;
    got = {bus.start_config, bus.ce, bus.start_weight_load, bus.start_feature_load,
           bus.weight_glb_rd_en, bus.feature_glb_rd_en, bus.bus_weight_valid,
           bus.bus_feature_valid, bus.psum_out_start, bus.done, bus.busy, 5'd0};
    checks++;
    if (got !== 16'h0) begin
      errors++;
      $display("FAIL %s control outputs: got %h expected 0000", tag, got);
    end
    checks++;
    if (bus.weight_glb_addr !== 7'd0 || bus.feature_glb_addr !== 6'd0) begin
      errors++;
      $display("FAIL %s addresses: got w=%0d f=%0d expected 0", tag, bus.weight_glb_addr,
               bus.feature_glb_addr);
    end
  endtask

  // One full pass. Caller is mid-cycle with the DUT in IDLE; returns mid-cycle in IDLE.
  task automatic run_pass(input bit md, input int wb, input int wl, input int fb, input int fl,
                          input int wpat, input int fpat, input bit hold, input bit pre_pulse,
                          input bit other_high, input int delay);
    int cyc, w_iss, f_iss, w_seen, f_seen, done_cnt, comp_cyc, flag_cyc;
    bit w_prev, f_prev, w_now, f_now, w_rdy, f_rdy, streaming, psum_seen, fin, sel;
    logic [6:0] wa;
    logic [5:0] fa;
    w_iss = 0; f_iss = 0; w_seen = 0; f_seen = 0; done_cnt = 0; comp_cyc = 0; flag_cyc = 0;
    w_prev = 0; f_prev = 0; psum_seen = 0; fin = 0;
    bus.mode = md;
    bus.w_base = 7'(wb); bus.w_len = 7'(wl);
    bus.f_base = 6'(fb); bus.f_len = 6'(fl);
    bus.start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    if (!hold) bus.start = 1'b0;
    while (!fin) begin
      if (psum_seen) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.psum_out_start !== 1'b0 || bus.done !== 1'b0 ||
            bus.start_config !== 1'b0) begin
          errors++;
          $display("FAIL idle_after_psum: busy=%b psum=%b done=%b cfg=%b expected all 0",
                   bus.busy, bus.psum_out_start, bus.done, bus.start_config);
        end
        fin = 1;
      end else begin
        checks++;
        if (bus.start_config !== (cyc == 1)) begin
          errors++;
          $display("FAIL start_config cyc %0d: got %b expected %b", cyc, bus.start_config,
                   cyc == 1);
        end
        checks++;
        if (bus.ce !== (cyc >= 2 && cyc <= CeCycles + 1)) begin
          errors++;
          $display("FAIL ce cyc %0d: got %b expected %b", cyc, bus.ce,
                   cyc >= 2 && cyc <= CeCycles + 1);
        end
        checks++;
        if (bus.start_weight_load !== (cyc == CeCycles + 2) ||
            bus.start_feature_load !== (cyc == CeCycles + 2)) begin
          errors++;
          $display("FAIL load_pulses cyc %0d: got %b%b expected %b", cyc,
                   bus.start_weight_load, bus.start_feature_load, cyc == CeCycles + 2);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL busy cyc %0d: got %b expected 1", cyc, bus.busy);
        end
        checks++;
        if (bus.bus_weight_valid !== w_prev || bus.bus_feature_valid !== f_prev) begin
          errors++;
          $display("FAIL valids cyc %0d: got w=%b f=%b expected w=%b f=%b", cyc,
                   bus.bus_weight_valid, bus.bus_feature_valid, w_prev, f_prev);
        end
        if (bus.bus_weight_valid === 1'b1) begin
          wa = 7'(wb + w_seen);
          checks++;
          if (bus.bus_weight_in !== wmem[wa]) begin
            errors++;
            $display("FAIL weight_data #%0d: got %h expected %h", w_seen, bus.bus_weight_in,
                     wmem[wa]);
          end
          w_seen++;
        end
        if (bus.bus_feature_valid === 1'b1) begin
          fa = 6'(fb + f_seen);
          checks++;
          if (bus.bus_feature_in !== fmem[fa]) begin
            errors++;
            $display("FAIL feature_data #%0d: got %h expected %h", f_seen, bus.bus_feature_in,
                     fmem[fa]);
          end
          f_seen++;
        end
        checks++;
        if (bus.done !== bus.psum_out_start) begin
          errors++;
          $display("FAIL done_vs_psum cyc %0d: done=%b psum=%b expected equal", cyc, bus.done,
                   bus.psum_out_start);
        end
        if (bus.done === 1'b1) done_cnt++;
        if (bus.psum_out_start === 1'b1) begin
          checks++;
          if (comp_cyc == 0 || cyc <= flag_cyc) begin
            errors++;
            $display("FAIL psum_early cyc %0d: got 1 expected 0 (flag from cyc %0d)", cyc,
                     flag_cyc);
          end
          psum_seen = 1;
        end
        if ((comp_cyc != 0 && cyc > flag_cyc + 12) || cyc > 600) begin
          errors++;
          $display("FAIL pass_timeout cyc %0d: got no psum expected psum", cyc);
          fin = 1;
        end
        streaming = (cyc >= CeCycles + 3);
        w_rdy = pick_ready(wpat, cyc - (CeCycles + 3));
        f_rdy = pick_ready(fpat, cyc - (CeCycles + 3));
        bus.pe_weight_load_ready = w_rdy;
        bus.pe_ifmap_load_ready = f_rdy;
        if (comp_cyc == 0 && streaming && w_seen == wl && f_seen == fl) begin
          comp_cyc = cyc;
          flag_cyc = cyc + delay;
        end
        sel = (pre_pulse && cyc == 2) || (comp_cyc != 0 && cyc >= flag_cyc);
        if (psum_seen) sel = 0;
        if (md) begin
          bus.clip_finish_flg = sel;
          bus.mac_finish = other_high;
        end else begin
          bus.mac_finish = sel;
          bus.clip_finish_flg = other_high;
        end
        #1;
        w_now = streaming && w_rdy && (w_iss < wl);
        f_now = streaming && f_rdy && (f_iss < fl);
        checks++;
        if (bus.weight_glb_rd_en !== w_now || bus.feature_glb_rd_en !== f_now) begin
          errors++;
          $display("FAIL rd_en cyc %0d: got w=%b f=%b expected w=%b f=%b", cyc,
                   bus.weight_glb_rd_en, bus.feature_glb_rd_en, w_now, f_now);
        end
        if (streaming && w_iss < wl) begin
          wa = 7'(wb + w_iss);
          checks++;
          if (bus.weight_glb_addr !== wa) begin
            errors++;
            $display("FAIL weight_addr cyc %0d: got %0d expected %0d", cyc,
                     bus.weight_glb_addr, wa);
          end
        end
        if (streaming && f_iss < fl) begin
          fa = 6'(fb + f_iss);
          checks++;
          if (bus.feature_glb_addr !== fa) begin
            errors++;
            $display("FAIL feature_addr cyc %0d: got %0d expected %0d", cyc,
                     bus.feature_glb_addr, fa);
          end
        end
        if (w_now) w_iss++;
        if (f_now) f_iss++;
        w_prev = w_now;
        f_prev = f_now;
        if (!fin) begin
          @(posedge clk); #1;
          cyc++;
        end
      end
    end
    bus.mac_finish = 1'b0;
    bus.clip_finish_flg = 1'b0;
    checks++;
    if (done_cnt != 1 || w_seen != wl || f_seen != fl) begin
      errors++;
      $display("FAIL pass_totals: got done=%0d w=%0d f=%0d expected done=1 w=%0d f=%0d",
               done_cnt, w_seen, f_seen, wl, fl);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset_hold");
    rst = 1'b0;
    bus.mode = 1'b0;
    bus.w_base = 7'd3; bus.w_len = 7'd20;
    bus.f_base = 6'd5; bus.f_len = 6'd20;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (bus.weight_glb_rd_en !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_load_reads: got rd_en=%b busy=%b expected 1 1", bus.weight_glb_rd_en,
               bus.busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_quiet("reset_mid_load");
    @(posedge clk); #1;
    check_quiet("after_reset_idle");
    run_pass(0, 0, 4, 0, 4, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_basic();
    fill_mem(0);
    run_pass(0, 0, 9, 0, 8, 0, 0, 0, 1, 0, 2);
  endtask

  task automatic test_ready_toggle();
    run_pass(0, 10, 11, 7, 6, 2, 1, 0, 0, 0, 0);
  endtask

  task automatic test_clip_mode();
    run_pass(1, 20, 0, 2, 12, 1, 1, 0, 1, 1, 5);
  endtask

  task automatic test_back_to_back();
    run_pass(0, 1, 3, 2, 5, 0, 0, 1, 0, 0, 0);
    run_pass(1, 4, 6, 9, 2, 1, 0, 1, 0, 0, 1);
    bus.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.start_config !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: got busy=%b cfg=%b expected 0 0", bus.busy, bus.start_config);
    end
  endtask

  task automatic test_wrap();
    run_pass(0, 125, 6, 60, 8, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    fill_mem(1);
    for (int n = 0; n < 8; n++) begin
      run_pass(1'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 24)), int'($urandom_range(0, 63)),
               int'($urandom_range(1, 24)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), 0, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.w_base = '0; bus.w_len = '0;
    bus.f_base = '0; bus.f_len = '0;
    bus.pe_weight_load_ready = 1'b1;
    bus.pe_ifmap_load_ready = 1'b1;
    bus.mac_finish = 1'b0;
    bus.clip_finish_flg = 1'b0;
    fill_mem(0);
    test_reset();
    test_basic();
    test_ready_toggle();
    test_clip_mode();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
